// File: rtl/ram_arbiter2.sv
// ram_arbiter2: round-robin arbiter sharing one sp_ram port between two masters, one transaction in flight.
// Optional macro RAM_ARB_PERF_EN adds saturating grant/conflict performance counters.
module ram_arbiter2 #(
  parameter int WIDTH      = 128,
  parameter int ADDR_WIDTH = 27,
  parameter int MASK_WIDTH = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0]      m0_din,
  input  logic [MASK_WIDTH-1:0] m0_mask,
  input  logic                  m0_re,
  input  logic                  m0_we,
  output logic [WIDTH-1:0]      m0_dout,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0]      m1_din,
  input  logic [MASK_WIDTH-1:0] m1_mask,
  input  logic                  m1_re,
  input  logic                  m1_we,
  output logic [WIDTH-1:0]      m1_dout,
  output logic                  m1_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_din,
  output logic [MASK_WIDTH-1:0] ram_mask,
  output logic                  ram_re,
  output logic                  ram_we,
  input  logic [WIDTH-1:0]      ram_dout,
  input  logic                  ram_ready
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]           grant0_count,
  output logic [31:0]           grant1_count,
  output logic [31:0]           conflict_count
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t                state_r, state_nxt_s;
  logic                  last_grant_r, last_grant_nxt_s;
  logic                  owner_r, owner_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  logic [WIDTH-1:0]      din_nxt_s;
  logic [MASK_WIDTH-1:0] mask_nxt_s;
  logic                  re_nxt_s, we_nxt_s;
  logic                  m0_ready_nxt_s, m1_ready_nxt_s;
  logic [WIDTH-1:0]      m0_dout_nxt_s, m1_dout_nxt_s;
  logic                  req0_s, req1_s, pick_m1_s, grant_s;

  assign req0_s    = m0_re | m0_we;
  assign req1_s    = m1_re | m1_we;
  // m1 wins when it is the only requester, or on a tie when m0 was served last
  assign pick_m1_s = req1_s & (~req0_s | ~last_grant_r);
  assign grant_s   = (state_r == IDLE) & (req0_s | req1_s);

  // Next-state and next-output logic for the arbiter FSM
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    owner_nxt_s      = owner_r;
    addr_nxt_s       = ram_addr;
    din_nxt_s        = ram_din;
    mask_nxt_s       = ram_mask;
    re_nxt_s         = ram_re;
    we_nxt_s         = ram_we;
    m0_ready_nxt_s   = 1'b0;
    m1_ready_nxt_s   = 1'b0;
    m0_dout_nxt_s    = m0_dout;
    m1_dout_nxt_s    = m1_dout;
    case (state_r)
      IDLE: begin
        re_nxt_s = 1'b0;
        we_nxt_s = 1'b0;
        if (grant_s) begin
          state_nxt_s      = BUSY;
          owner_nxt_s      = pick_m1_s;
          last_grant_nxt_s = pick_m1_s;
          if (pick_m1_s) begin
            addr_nxt_s = m1_addr;
            din_nxt_s  = m1_din;
            mask_nxt_s = m1_mask;
            we_nxt_s   = m1_we;
            re_nxt_s   = m1_re & ~m1_we;
          end else begin
            addr_nxt_s = m0_addr;
            din_nxt_s  = m0_din;
            mask_nxt_s = m0_mask;
            we_nxt_s   = m0_we;
            re_nxt_s   = m0_re & ~m0_we;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (ram_ready) begin
          state_nxt_s = RESP;
          re_nxt_s    = 1'b0;
          we_nxt_s    = 1'b0;
          // Read data is only captured for reads; writes keep the old dout
          if (owner_r) begin
            m1_ready_nxt_s = 1'b1;
            if (ram_re) begin
              m1_dout_nxt_s = ram_dout;
            end else begin
              m1_dout_nxt_s = m1_dout;
            end
          end else begin
            m0_ready_nxt_s = 1'b1;
            if (ram_re) begin
              m0_dout_nxt_s = ram_dout;
            end else begin
              m0_dout_nxt_s = m0_dout;
            end
          end
        end else begin
          state_nxt_s = BUSY;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        re_nxt_s    = 1'b0;
        we_nxt_s    = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      ram_addr     <= {ADDR_WIDTH{1'b0}};
      ram_din      <= {WIDTH{1'b0}};
      ram_mask     <= {MASK_WIDTH{1'b0}};
      ram_re       <= 1'b0;
      ram_we       <= 1'b0;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      m0_dout      <= {WIDTH{1'b0}};
      m1_dout      <= {WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      owner_r      <= owner_nxt_s;
      ram_addr     <= addr_nxt_s;
      ram_din      <= din_nxt_s;
      ram_mask     <= mask_nxt_s;
      ram_re       <= re_nxt_s;
      ram_we       <= we_nxt_s;
      m0_ready     <= m0_ready_nxt_s;
      m1_ready     <= m1_ready_nxt_s;
      m0_dout      <= m0_dout_nxt_s;
      m1_dout      <= m1_dout_nxt_s;
    end
  end

`ifdef RAM_ARB_PERF_EN
  // Saturating grant and conflict counters
  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_count   <= 32'd0;
      grant1_count   <= 32'd0;
      conflict_count <= 32'd0;
    end else begin
      if (grant_s && !pick_m1_s && (grant0_count != 32'hFFFF_FFFF)) begin
        grant0_count <= grant0_count + 32'd1;
      end
      if (grant_s && pick_m1_s && (grant1_count != 32'hFFFF_FFFF)) begin
        grant1_count <= grant1_count + 32'd1;
      end
      if ((state_r == IDLE) && req0_s && req1_s && (conflict_count != 32'hFFFF_FFFF)) begin
        conflict_count <= conflict_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter2.sv
// Directed self-checking bench for ram_arbiter2; a negedge responder stands in for sp_ram.
// Define RAM_ARB_PERF_EN to also exercise the performance counters.
module tb_ram_arbiter2;
  localparam int W  = 128;
  localparam int AW = 27;
  localparam int MW = 16;

  logic          clk, rst;
  logic [AW-1:0] m0_addr, m1_addr, ram_addr;
  logic [W-1:0]  m0_din, m1_din, m0_dout, m1_dout, ram_din, ram_dout;
  logic [MW-1:0] m0_mask, m1_mask, ram_mask;
  logic          m0_re, m0_we, m1_re, m1_we, m0_ready, m1_ready;
  logic          ram_re, ram_we, ram_ready;
`ifdef RAM_ARB_PERF_EN
  logic [31:0]   grant0_count, grant1_count, conflict_count;
`endif

  int            n_checks = 0;
  int            n_fail = 0;
  int            resp_delay = 0;
  int            wait_cnt = 0;
  bit            resp_en = 1'b1;
  logic          inject_ready = 1'b0;
  logic [W-1:0]  rd_data = {W{1'b0}};

  ram_arbiter2 #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_mask(m0_mask), .m0_re(m0_re), .m0_we(m0_we),
    .m0_dout(m0_dout), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_mask(m1_mask), .m1_re(m1_re), .m1_we(m1_we),
    .m1_dout(m1_dout), .m1_ready(m1_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_mask(ram_mask), .ram_re(ram_re), .ram_we(ram_we),
    .ram_dout(ram_dout), .ram_ready(ram_ready)
`ifdef RAM_ARB_PERF_EN
    , .grant0_count(grant0_count), .grant1_count(grant1_count), .conflict_count(conflict_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sp_ram stand-in: ready after resp_delay extra cycles of a held strobe; dout is junk otherwise
  always @(negedge clk) begin
    if (!resp_en) begin
      ram_ready = inject_ready;
      wait_cnt  = 0;
    end else if ((ram_re || ram_we) && !ram_ready) begin
      if (wait_cnt >= resp_delay) begin
        ram_ready = 1'b1;
        ram_dout  = rd_data;
        wait_cnt  = 0;
      end else begin
        wait_cnt  = wait_cnt + 1;
        ram_dout  = ~rd_data;
      end
    end else begin
      ram_ready = 1'b0;
      wait_cnt  = 0;
      ram_dout  = ~rd_data;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ram_re, ram_we, m0_ready, m1_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 0000", {ram_re, ram_we, m0_ready, m1_ready});
    end
    n_checks++;
    if ({ram_addr, ram_din, ram_mask} !== {(AW + W + MW){1'b0}}) begin
      n_fail++; $display("FAIL reset_ram_bus: addr %h din %h mask %h required all 0", ram_addr, ram_din, ram_mask);
    end
    n_checks++;
    if ({m0_dout, m1_dout} !== {(2 * W){1'b0}}) begin
      n_fail++; $display("FAIL reset_dout: got %h / %h required 0", m0_dout, m1_dout);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    rd_data = {16{8'hA5}};
    m0_addr = 27'h10;
    m0_re   = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ram_re, ram_we, ram_addr} !== {2'b10, 27'h10}) begin
      n_fail++; $display("FAIL read_issue: re %b we %b addr %h required 1 0 10", ram_re, ram_we, ram_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({ram_re, m0_ready, m1_ready} !== 3'b010) begin
      n_fail++; $display("FAIL read_ready: re %b m0_ready %b m1_ready %b required 0 1 0", ram_re, m0_ready, m1_ready);
    end
    n_checks++;
    if (m0_dout !== {16{8'hA5}}) begin
      n_fail++; $display("FAIL read_dout: got %h required a5..a5", m0_dout);
    end
    m0_re = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ram_re, ram_we, m0_ready, m1_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL read_after: got %b required 0000", {ram_re, ram_we, m0_ready, m1_ready});
    end
  endtask

  task automatic test_masked_write();
    m1_addr = 27'h20;
    m1_din  = 128'h1234;
    m1_mask = 16'h000F;
    m1_we   = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ram_re, ram_we, ram_addr, ram_mask, ram_din} !== {2'b01, 27'h20, 16'h000F, 128'h1234}) begin
      n_fail++; $display("FAIL write_issue: re %b we %b addr %h mask %h din %h", ram_re, ram_we, ram_addr, ram_mask, ram_din);
    end
    @(negedge clk);
    n_checks++;
    if ({ram_we, m0_ready, m1_ready} !== 3'b001) begin
      n_fail++; $display("FAIL write_ready: we %b m0_ready %b m1_ready %b required 0 0 1", ram_we, m0_ready, m1_ready);
    end
    n_checks++;
    if (m1_dout !== {W{1'b0}} || m0_dout !== {16{8'hA5}}) begin
      n_fail++; $display("FAIL write_dout: m1 %h (required 0) m0 %h (required a5..)", m1_dout, m0_dout);
    end
    m1_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m1_ready !== 1'b0) begin
      n_fail++; $display("FAIL write_pulse: m1_ready %b required 0", m1_ready);
    end
  endtask

  task automatic test_rw_both();
    m0_addr = 27'h30;
    m0_din  = 128'hCAFE;
    m0_mask = 16'hFFFF;
    m0_re   = 1'b1;
    m0_we   = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ram_re, ram_we, ram_din} !== {2'b01, 128'hCAFE}) begin
      n_fail++; $display("FAIL rw_issue: re %b we %b din %h required 0 1 cafe", ram_re, ram_we, ram_din);
    end
    @(negedge clk);
    n_checks++;
    if (m0_ready !== 1'b1 || m0_dout !== {16{8'hA5}}) begin
      n_fail++; $display("FAIL rw_done: ready %b dout %h required 1 a5..", m0_ready, m0_dout);
    end
    m0_re = 1'b0;
    m0_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr;
    int            n_grants = 0;
    bit            prev_re = 1'b0;
    bit            done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    m0_addr = 27'h100;
    m1_addr = 27'h200;
    m0_re   = 1'b1;
    m1_re   = 1'b1;
    for (int cyc = 0; cyc < 100 && n_grants < 6; cyc++) begin
      @(negedge clk);
      m0_re = 1'b1;
      m1_re = 1'b1;
      if (ram_re && !prev_re) begin
        exp_addr = (n_grants % 2 == 0) ? 27'h100 : 27'h200;
        n_checks++;
        if (ram_addr !== exp_addr) begin
          n_fail++; $display("FAIL rr_grant%0d: addr %h required %h", n_grants, ram_addr, exp_addr);
        end
        n_grants++;
      end
      prev_re = ram_re;
      if (m0_ready) m0_re = 1'b0;
      if (m1_ready) m1_re = 1'b0;
    end
    n_checks++;
    if (n_grants != 6) begin
      n_fail++; $display("FAIL rr_count: got %0d grants required 6", n_grants);
    end
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (m1_ready) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL rr_drain: m1_ready timeout got 0 required 1");
    end
    m0_re = 1'b0;
    m1_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_slow_ram();
    int stable = 0;
    resp_delay = 20;
    rd_data    = {16{8'h5A}};
    m0_addr    = 27'h300;
    m0_re      = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (ram_re === 1'b1 && ram_we === 1'b0 && ram_addr === 27'h300 && m0_ready === 1'b0 && m1_ready === 1'b0)
        stable++;
      if (i == 1) begin
        m1_addr = 27'h400;
        m1_re   = 1'b1;
      end
    end
    n_checks++;
    if (stable != 21) begin
      n_fail++; $display("FAIL slow_stable: %0d stable cycles required 21", stable);
    end
    @(negedge clk);
    n_checks++;
    if ({ram_re, m0_ready, m1_ready} !== 3'b010 || m0_dout !== {16{8'h5A}}) begin
      n_fail++; $display("FAIL slow_done: re %b r0 %b r1 %b dout %h", ram_re, m0_ready, m1_ready, m0_dout);
    end
    resp_delay = 0;
    m0_re      = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ram_re !== 1'b0) begin
      n_fail++; $display("FAIL slow_no_resp_grant: ram_re %b required 0", ram_re);
    end
    @(negedge clk);
    n_checks++;
    if (ram_re !== 1'b1 || ram_addr !== 27'h400) begin
      n_fail++; $display("FAIL slow_m1_grant: re %b addr %h required 1 400", ram_re, ram_addr);
    end
    @(negedge clk);
    n_checks++;
    if (m1_ready !== 1'b1 || m1_dout !== {16{8'h5A}}) begin
      n_fail++; $display("FAIL slow_m1_done: ready %b dout %h", m1_ready, m1_dout);
    end
    m1_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    resp_delay = 50;
    m0_addr    = 27'h500;
    m0_din     = 128'hBEEF;
    m0_we      = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b1) begin
      n_fail++; $display("FAIL midrst_busy: ram_we %b required 1", ram_we);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ram_re, ram_we, m0_ready, m1_ready} !== 4'b0000 || ram_addr !== {AW{1'b0}} || m0_dout !== {W{1'b0}}) begin
      n_fail++; $display("FAIL midrst_clear: strobes %b addr %h dout %h", {ram_re, ram_we, m0_ready, m1_ready}, ram_addr, m0_dout);
    end
    rst        = 1'b0;
    m0_we      = 1'b0;
    resp_delay = 0;
    rd_data    = {16{8'h77}};
    m0_addr    = 27'h600;
    m0_re      = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ram_re !== 1'b1 || ram_addr !== 27'h600) begin
      n_fail++; $display("FAIL midrst_regrant: re %b addr %h required 1 600", ram_re, ram_addr);
    end
    @(negedge clk);
    n_checks++;
    if (m0_ready !== 1'b1 || m0_dout !== {16{8'h77}}) begin
      n_fail++; $display("FAIL midrst_done: ready %b dout %h", m0_ready, m0_dout);
    end
    m0_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ready_outside_busy();
    resp_en      = 1'b0;
    inject_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    inject_ready = 1'b0;
    n_checks++;
    if ({ram_re, ram_we, m0_ready, m1_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL stray_ready: got %b required 0000", {ram_re, ram_we, m0_ready, m1_ready});
    end
    @(negedge clk);
    n_checks++;
    if ({ram_re, ram_we, m0_ready, m1_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL stray_ready2: got %b required 0000", {ram_re, ram_we, m0_ready, m1_ready});
    end
    resp_en = 1'b1;
    @(negedge clk);
  endtask

`ifdef RAM_ARB_PERF_EN
  task automatic test_perf();
    int n_grants = 0;
    bit prev_re = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m0_re = 1'b1;
    m1_re = 1'b1;
    for (int cyc = 0; cyc < 200 && n_grants < 10; cyc++) begin
      @(negedge clk);
      m0_re = 1'b1;
      m1_re = 1'b1;
      if (ram_re && !prev_re) n_grants++;
      prev_re = ram_re;
      if (m0_ready) m0_re = 1'b0;
      if (m1_ready) m1_re = 1'b0;
    end
    @(negedge clk);
    m0_re = 1'b0;
    m1_re = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (grant0_count !== 32'd5 || grant1_count !== 32'd5 || conflict_count < 32'd5) begin
      n_fail++; $display("FAIL perf_counts: g0 %0d g1 %0d conf %0d required 5 5 >=5", grant0_count, grant1_count, conflict_count);
    end
    force dut.grant0_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.grant0_count;
    m0_re = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m0_re = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant0_count !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL perf_saturate: got %h required ffffffff", grant0_count);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {m0_addr, m1_addr} = {(2 * AW){1'b0}};
    {m0_din, m1_din}   = {(2 * W){1'b0}};
    {m0_mask, m1_mask} = {(2 * MW){1'b0}};
    {m0_re, m0_we, m1_re, m1_we} = 4'b0000;
    test_reset();
    test_single_read();
    test_masked_write();
    test_rw_both();
    test_back_to_back();
    test_slow_ram();
    test_reset_mid_op();
    test_ready_outside_busy();
`ifdef RAM_ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
